// File: rtl/ocx_tlx_framer_cmd_fifo_cfg.sv
// ocx_tlx_framer_cmd_fifo_cfg
// First-word-fall-through command FIFO between the command arbiter and the
// framer flit builder.
// - Depth can be programmed at run time.
// - Provides full / almost-full flags, sticky overflow/underflow errors,
//   a high-water mark and one credit pulse per accepted read.
module ocx_tlx_framer_cmd_fifo_cfg #(
  parameter int WIDTH        = 172,
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  wr_enable,
  output logic [WIDTH-1:0]      data_out,
  input  logic                  rd_done,
  input  logic [ADDR_WIDTH:0]   cfg_depth_limit,
  input  logic                  stat_clear,
  output logic                  data_available,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   valid_entry_count,
  output logic [ADDR_WIDTH:0]   high_water_mark,
  output logic                  credit_return,
  output logic                  underflow_error,
  output logic                  overflow_error
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         eff_depth_r;
  logic [CW-1:0]         hwm_r;
  logic                  credit_r;
  logic                  uf_err_r;
  logic                  of_err_r;

  logic                  empty_s;
  logic                  full_s;
  logic                  ra_s;
  logic                  wa_s;
  logic                  reload_s;
  logic                  of_set_s;
  logic                  uf_set_s;
  logic [CW-1:0]         count_next_s;
  logic [CW-1:0]         cfg_dec_s;
  logic [CW-1:0]         af_lim_s;
  logic [CW-1:0]         hwm_next_s;
  logic [ADDR_WIDTH-1:0] wr_ptr_inc_s;
  logic [ADDR_WIDTH-1:0] rd_ptr_inc_s;

  assign empty_s  = (count_r == {CW{1'b0}});
  assign full_s   = (count_r == eff_depth_r);
  assign ra_s     = rd_done && !empty_s;
  assign wa_s     = wr_enable && (!full_s || ra_s);
  assign of_set_s = wr_enable && full_s && !ra_s;
  assign uf_set_s = rd_done && empty_s;
  // Depth is only retuned while nothing is stored and nothing is arriving.
  assign reload_s = empty_s && !wr_enable;

  // Decode the requested depth and the almost-full limit; the next occupancy
  // feeds the high-water mark.
  always_comb begin
    cfg_dec_s    = CW'(DEPTH);
    af_lim_s     = eff_depth_r;
    count_next_s = count_r;
    hwm_next_s   = hwm_r;
    if ((cfg_depth_limit == {CW{1'b0}}) || (cfg_depth_limit > CW'(DEPTH))) begin
      cfg_dec_s = CW'(DEPTH);
    end else begin
      cfg_dec_s = cfg_depth_limit;
    end
    if (CW'(AFULL_THRESH) < eff_depth_r) begin
      af_lim_s = CW'(AFULL_THRESH);
    end else begin
      af_lim_s = eff_depth_r;
    end
    if (wa_s && !ra_s) begin
      count_next_s = count_r + CW'(1);
    end else if (ra_s && !wa_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
    if (count_next_s > hwm_r) begin
      hwm_next_s = count_next_s;
    end else begin
      hwm_next_s = hwm_r;
    end
  end

  // Pointer increments wrap at the effective depth, not at a power of two.
  always_comb begin
    wr_ptr_inc_s = wr_ptr_r + ADDR_WIDTH'(1);
    rd_ptr_inc_s = rd_ptr_r + ADDR_WIDTH'(1);
    if ({1'b0, wr_ptr_r} == (eff_depth_r - CW'(1))) begin
      wr_ptr_inc_s = {ADDR_WIDTH{1'b0}};
    end else begin
      wr_ptr_inc_s = wr_ptr_r + ADDR_WIDTH'(1);
    end
    if ({1'b0, rd_ptr_r} == (eff_depth_r - CW'(1))) begin
      rd_ptr_inc_s = {ADDR_WIDTH{1'b0}};
    end else begin
      rd_ptr_inc_s = rd_ptr_r + ADDR_WIDTH'(1);
    end
  end

  // Control state: pointers, occupancy, depth, statistics and credit.
  // Pointers are re-based to 0 when the depth reloads so they always lie
  // inside the newly selected depth (invisible while the FIFO is empty).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
      count_r     <= {CW{1'b0}};
      eff_depth_r <= CW'(DEPTH);
      hwm_r       <= {CW{1'b0}};
      credit_r    <= 1'b0;
      uf_err_r    <= 1'b0;
      of_err_r    <= 1'b0;
    end else begin
      if (reload_s) begin
        eff_depth_r <= cfg_dec_s;
        wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
        rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
      end else begin
        if (wa_s) begin
          wr_ptr_r <= wr_ptr_inc_s;
        end
        if (ra_s) begin
          rd_ptr_r <= rd_ptr_inc_s;
        end
      end
      count_r  <= count_next_s;
      credit_r <= ra_s;
      if (stat_clear) begin
        hwm_r    <= count_next_s;
        uf_err_r <= 1'b0;
        of_err_r <= 1'b0;
      end else begin
        hwm_r <= hwm_next_s;
        if (uf_set_s) begin
          uf_err_r <= 1'b1;
        end
        if (of_set_s) begin
          of_err_r <= 1'b1;
        end
      end
    end
  end

  // Storage array; not reset, and a write coinciding with reset is discarded.
  always_ff @(posedge clock) begin
    if (wa_s && !reset) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Head entry falls through; forced to zero when nothing is stored.
  always_comb begin
    if (empty_s) begin
      data_out = {WIDTH{1'b0}};
    end else begin
      data_out = mem_r[rd_ptr_r];
    end
  end

  assign data_available    = !empty_s;
  assign full              = full_s;
  assign almost_full       = (count_r >= af_lim_s);
  assign valid_entry_count = count_r;
  assign high_water_mark   = hwm_r;
  assign credit_return     = credit_r;
  assign underflow_error   = uf_err_r;
  assign overflow_error    = of_err_r;

endmodule

// File: tb/tb_ocx_tlx_framer_cmd_fifo_cfg.sv
// Directed self-checking bench for ocx_tlx_framer_cmd_fifo_cfg (default parameters).
module tb_ocx_tlx_framer_cmd_fifo_cfg;

  logic         clock;
  logic         reset;
  logic [171:0] data_in;
  logic         wr_enable;
  logic [171:0] data_out;
  logic         rd_done;
  logic [3:0]   cfg_depth_limit;
  logic         stat_clear;
  logic         data_available;
  logic         full;
  logic         almost_full;
  logic [3:0]   valid_entry_count;
  logic [3:0]   high_water_mark;
  logic         credit_return;
  logic         underflow_error;
  logic         overflow_error;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ocx_tlx_framer_cmd_fifo_cfg dut (
    .clock(clock), .reset(reset), .data_in(data_in), .wr_enable(wr_enable),
    .data_out(data_out), .rd_done(rd_done), .cfg_depth_limit(cfg_depth_limit),
    .stat_clear(stat_clear), .data_available(data_available), .full(full),
    .almost_full(almost_full), .valid_entry_count(valid_entry_count),
    .high_water_mark(high_water_mark), .credit_return(credit_return),
    .underflow_error(underflow_error), .overflow_error(overflow_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [171:0] mk(input logic [7:0] tag, input logic [7:0] idx);
    logic [171:0] v;
    v = 172'd0;
    v[7:0]     = idx;
    v[90:83]   = tag ^ idx;
    v[171:164] = tag;
    return v;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    total_cnt++; if (valid_entry_count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", valid_entry_count); else pass_cnt++;
    total_cnt++; if (data_available !== 1'b0) $display("FAIL reset_avail got=%0b exp=0", data_available); else pass_cnt++;
    total_cnt++; if (full !== 1'b0 || almost_full !== 1'b0) $display("FAIL reset_flags got=%0b%0b exp=00", full, almost_full); else pass_cnt++;
    total_cnt++; if (high_water_mark !== 4'd0) $display("FAIL reset_hwm got=%0d exp=0", high_water_mark); else pass_cnt++;
    total_cnt++; if (data_out !== 172'd0) $display("FAIL reset_data got=%0h exp=0", data_out); else pass_cnt++;
    total_cnt++; if (credit_return !== 1'b0 || underflow_error !== 1'b0 || overflow_error !== 1'b0)
      $display("FAIL reset_misc got=%0b%0b%0b exp=000", credit_return, underflow_error, overflow_error); else pass_cnt++;
  endtask

  task automatic test_fill_drain;
    cfg_depth_limit = 4'd0;
    tick();
    for (int i = 0; i < 8; i++) begin
      wr_enable = 1'b1; data_in = mk(8'hD0, 8'(i));
      tick();
      total_cnt++; if (valid_entry_count !== 4'(i + 1)) $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, valid_entry_count, i + 1); else pass_cnt++;
      total_cnt++; if (almost_full !== (i + 1 >= 6)) $display("FAIL fill_afull[%0d] got=%0b exp=%0b", i, almost_full, (i + 1 >= 6)); else pass_cnt++;
      total_cnt++; if (full !== (i + 1 == 8)) $display("FAIL fill_full[%0d] got=%0b exp=%0b", i, full, (i + 1 == 8)); else pass_cnt++;
    end
    wr_enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total_cnt++; if (data_out !== mk(8'hD0, 8'(i))) $display("FAIL drain_data[%0d] got=%0h exp=%0h", i, data_out, mk(8'hD0, 8'(i))); else pass_cnt++;
      rd_done = 1'b1;
      tick();
      total_cnt++; if (credit_return !== 1'b1) $display("FAIL drain_credit[%0d] got=%0b exp=1", i, credit_return); else pass_cnt++;
    end
    rd_done = 1'b0;
    total_cnt++; if (valid_entry_count !== 4'd0) $display("FAIL drain_count got=%0d exp=0", valid_entry_count); else pass_cnt++;
    total_cnt++; if (data_out !== 172'd0) $display("FAIL drain_zero got=%0h exp=0", data_out); else pass_cnt++;
    total_cnt++; if (high_water_mark !== 4'd8) $display("FAIL drain_hwm got=%0d exp=8", high_water_mark); else pass_cnt++;
    tick();
    total_cnt++; if (credit_return !== 1'b0) $display("FAIL drain_credit_end got=%0b exp=0", credit_return); else pass_cnt++;
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 8; i++) begin
      wr_enable = 1'b1; data_in = mk(8'hE0, 8'(i));
      tick();
    end
    data_in = mk(8'hEE, 8'hFF);
    tick();
    total_cnt++; if (overflow_error !== 1'b1) $display("FAIL ovf_flag got=%0b exp=1", overflow_error); else pass_cnt++;
    total_cnt++; if (valid_entry_count !== 4'd8) $display("FAIL ovf_count got=%0d exp=8", valid_entry_count); else pass_cnt++;
    total_cnt++; if (data_out !== mk(8'hE0, 8'd0)) $display("FAIL ovf_head got=%0h exp=%0h", data_out, mk(8'hE0, 8'd0)); else pass_cnt++;
    data_in = mk(8'hF0, 8'd1); rd_done = 1'b1;
    tick();
    wr_enable = 1'b0; rd_done = 1'b0;
    total_cnt++; if (valid_entry_count !== 4'd8) $display("FAIL fullrw_count got=%0d exp=8", valid_entry_count); else pass_cnt++;
    total_cnt++; if (credit_return !== 1'b1) $display("FAIL fullrw_credit got=%0b exp=1", credit_return); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      logic [171:0] e;
      e = (i < 7) ? mk(8'hE0, 8'(i + 1)) : mk(8'hF0, 8'd1);
      total_cnt++; if (data_out !== e) $display("FAIL fullrw_order[%0d] got=%0h exp=%0h", i, data_out, e); else pass_cnt++;
      rd_done = 1'b1;
      tick();
    end
    rd_done = 1'b0; stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    total_cnt++; if (overflow_error !== 1'b0) $display("FAIL ovf_clear got=%0b exp=0", overflow_error); else pass_cnt++;
  endtask

  task automatic test_underflow;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    total_cnt++; if (underflow_error !== 1'b1) $display("FAIL udf_flag got=%0b exp=1", underflow_error); else pass_cnt++;
    total_cnt++; if (valid_entry_count !== 4'd0 || credit_return !== 1'b0)
      $display("FAIL udf_state got=%0d/%0b exp=0/0", valid_entry_count, credit_return); else pass_cnt++;
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    total_cnt++; if (underflow_error !== 1'b0) $display("FAIL udf_clear got=%0b exp=0", underflow_error); else pass_cnt++;
    rd_done = 1'b1; stat_clear = 1'b1;
    tick();
    rd_done = 1'b0; stat_clear = 1'b0;
    total_cnt++; if (underflow_error !== 1'b0) $display("FAIL udf_clear_prio got=%0b exp=0", underflow_error); else pass_cnt++;
  endtask

  task automatic test_depth_limit;
    logic [171:0] q[$];
    cfg_depth_limit = 4'd3;
    tick();
    for (int i = 0; i < 3; i++) begin
      wr_enable = 1'b1; data_in = mk(8'hA0, 8'(i)); q.push_back(data_in);
      tick();
      total_cnt++; if (full !== (i == 2) || almost_full !== (i == 2))
        $display("FAIL lim_flags[%0d] got=%0b%0b exp=%0b%0b", i, full, almost_full, (i == 2), (i == 2)); else pass_cnt++;
    end
    data_in = mk(8'hAA, 8'hAA);
    tick();
    wr_enable = 1'b0;
    total_cnt++; if (valid_entry_count !== 4'd3 || overflow_error !== 1'b1)
      $display("FAIL lim_drop got=%0d/%0b exp=3/1", valid_entry_count, overflow_error); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      total_cnt++; if (data_out !== q[0]) $display("FAIL lim_wrap[%0d] got=%0h exp=%0h", i, data_out, q[0]); else pass_cnt++;
      wr_enable = 1'b1; rd_done = 1'b1; data_in = mk(8'hB0, 8'(i));
      tick();
      void'(q.pop_front()); q.push_back(data_in);
      total_cnt++; if (valid_entry_count !== 4'd3) $display("FAIL lim_wrap_count[%0d] got=%0d exp=3", i, valid_entry_count); else pass_cnt++;
    end
    wr_enable = 1'b0; rd_done = 1'b0; cfg_depth_limit = 4'd5;
    tick();
    total_cnt++; if (full !== 1'b1) $display("FAIL lim_cfg_ignored got=%0b exp=1", full); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (data_out !== q[0]) $display("FAIL lim_drain[%0d] got=%0h exp=%0h", i, data_out, q[0]); else pass_cnt++;
      rd_done = 1'b1;
      tick();
      void'(q.pop_front());
    end
    rd_done = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      wr_enable = 1'b1; data_in = mk(8'hC0, 8'(i));
      tick();
    end
    wr_enable = 1'b0;
    total_cnt++; if (valid_entry_count !== 4'd5 || full !== 1'b1 || almost_full !== 1'b1)
      $display("FAIL lim5 got=%0d/%0b%0b exp=5/11", valid_entry_count, full, almost_full); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      rd_done = 1'b1;
      tick();
    end
    rd_done = 1'b0; cfg_depth_limit = 4'd0; stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
  endtask

  task automatic test_hwm_reset;
    for (int i = 0; i < 5; i++) begin
      wr_enable = 1'b1; data_in = mk(8'h50, 8'(i));
      tick();
    end
    wr_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_done = 1'b1;
      tick();
    end
    rd_done = 1'b0;
    total_cnt++; if (high_water_mark !== 4'd5) $display("FAIL hwm got=%0d exp=5", high_water_mark); else pass_cnt++;
    wr_enable = 1'b1; data_in = mk(8'h60, 8'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    total_cnt++; if (valid_entry_count !== 4'd0 || data_available !== 1'b0 || data_out !== 172'd0 || high_water_mark !== 4'd0)
      $display("FAIL midreset got=%0d/%0b/%0h/%0d exp=0/0/0/0", valid_entry_count, data_available, data_out, high_water_mark); else pass_cnt++;
    tick();
    reset = 1'b0; wr_enable = 1'b0;
    tick();
    total_cnt++; if (valid_entry_count !== 4'd0 || data_out !== 172'd0)
      $display("FAIL postreset got=%0d/%0h exp=0/0", valid_entry_count, data_out); else pass_cnt++;
  endtask

  task automatic test_simul_empty;
    wr_enable = 1'b1; rd_done = 1'b1; data_in = mk(8'h77, 8'h77);
    tick();
    wr_enable = 1'b0; rd_done = 1'b0;
    total_cnt++; if (valid_entry_count !== 4'd1) $display("FAIL simul_count got=%0d exp=1", valid_entry_count); else pass_cnt++;
    total_cnt++; if (data_out !== mk(8'h77, 8'h77)) $display("FAIL simul_data got=%0h exp=%0h", data_out, mk(8'h77, 8'h77)); else pass_cnt++;
    total_cnt++; if (underflow_error !== 1'b1 || credit_return !== 1'b0)
      $display("FAIL simul_flags got=%0b/%0b exp=1/0", underflow_error, credit_return); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; wr_enable = 1'b0; rd_done = 1'b0; stat_clear = 1'b0;
    cfg_depth_limit = 4'd0; data_in = 172'd0;
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_depth_limit();
    test_hwm_reset();
    test_simul_empty();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
